// File: rtl/simple_processor_pkg.sv
// Shared processor-wide constants used as defaults by pipeline blocks.
package simple_processor_pkg;
  localparam int unsigned DATA_WIDTH = 32;
endpackage

// File: rtl/alu_wb_buffer_if.sv
// ALU-result push port, register-file write port and hazard lookup of alu_wb_buffer.
interface alu_wb_buffer_if #(
  parameter int unsigned DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] result_i;
  logic [ADDR_WIDTH-1:0] rd_addr_i;
  logic                  wb_en_i;
  logic                  wr_valid_o;
  logic                  wr_ready_i;
  logic [DATA_WIDTH-1:0] wr_data_o;
  logic [ADDR_WIDTH-1:0] wr_addr_o;
  logic                  wr_en_o;
  logic [ADDR_WIDTH-1:0] lookup_addr_i;
  logic                  pending_hit_o;
  logic [1:0]            count_o;

  modport master (
    output in_valid_i, result_i, rd_addr_i, wb_en_i, wr_ready_i, lookup_addr_i,
    input  in_ready_o, wr_valid_o, wr_data_o, wr_addr_o, wr_en_o, pending_hit_o, count_o
  );

  modport slave (
    input  in_valid_i, result_i, rd_addr_i, wb_en_i, wr_ready_i, lookup_addr_i,
    output in_ready_o, wr_valid_o, wr_data_o, wr_addr_o, wr_en_o, pending_hit_o, count_o
  );
endinterface

// File: rtl/alu_wb_buffer.sv
// Two-entry in-order writeback buffer between the ALU and the register-file write port,
// with a hazard lookup over buffered entries.
module alu_wb_buffer #(
  parameter int unsigned DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input logic            clk_i,
  input logic            rst_i,
  alu_wb_buffer_if.slave bus
);
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DEPTH-1:0]      wben_q;
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [CNT_W-1:0]      count_q;

  logic             full_c;
  logic             empty_c;
  logic             push_c;
  logic             pop_c;
  logic             head_wr_c;
  logic [DEPTH-1:0] slot_hit_c;

  // Ready/valid come from registered occupancy only; wr_ready_i never reaches in_ready_o.
  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign push_c  = bus.in_valid_i && !full_c && !rst_i;
  assign pop_c   = bus.wr_ready_i && !empty_c && !rst_i;

  // x0 is hardwired zero, so a write to it is swallowed while the entry still pops.
  assign head_wr_c = wben_q[rd_ptr_q] && (addr_q[rd_ptr_q] != '0);

  always_comb begin
    slot_hit_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot_hit_c[i] = (full_c || (!empty_c && (rd_ptr_q == 1'(i))))
                    && wben_q[i]
                    && (addr_q[1'(i)] == bus.lookup_addr_i)
                    && (bus.lookup_addr_i != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      wben_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[1'(i)] <= '0;
        addr_q[1'(i)] <= '0;
      end
    end else begin
      if (push_c) begin
        data_q[wr_ptr_q] <= bus.result_i;
        addr_q[wr_ptr_q] <= bus.rd_addr_i;
        wben_q[wr_ptr_q] <= bus.wb_en_i;
        wr_ptr_q         <= !wr_ptr_q;
      end
      if (pop_c) begin
        rd_ptr_q <= !rd_ptr_q;
      end
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.in_ready_o    = !full_c;
  assign bus.wr_valid_o    = !empty_c;
  assign bus.wr_data_o     = data_q[rd_ptr_q];
  assign bus.wr_addr_o     = addr_q[rd_ptr_q];
  assign bus.wr_en_o       = pop_c && head_wr_c;
  assign bus.pending_hit_o = |slot_hit_c;
  assign bus.count_o       = count_q;
endmodule

// File: tb/tb_alu_wb_buffer.sv
// Scoreboard bench for alu_wb_buffer: queue reference model, directed scenarios, then random traffic.
module tb_alu_wb_buffer;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          wben;
  } ent_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  ent_t exp_q[$];

  alu_wb_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  alu_wb_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Any stored entry that will write the looked-up non-zero register.
  function automatic logic model_hit(input logic [AW-1:0] lk);
    logic hit = 1'b0;
    foreach (exp_q[i]) begin
      if (exp_q[i].wben && exp_q[i].addr == lk && lk != '0) hit = 1'b1;
    end
    return hit;
  endfunction

  // One clock of stimulus: check settled state against the model, then record an accepted push.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [AW-1:0] a,
                       input logic w, input logic rdy, input logic [AW-1:0] lk, input logic r);
    int sz;
    @(posedge clk);
    #1;
    bus.in_valid_i    = v;
    bus.result_i      = d;
    bus.rd_addr_i     = a;
    bus.wb_en_i       = w;
    bus.wr_ready_i    = rdy;
    bus.lookup_addr_i = lk;
    rst               = r;
    #2;
    sz = exp_q.size();
    chk("count", DW'(bus.count_o), DW'(sz));
    chk("in_ready", DW'(bus.in_ready_o), DW'(sz != 2));
    chk("wr_valid", DW'(bus.wr_valid_o), DW'(sz != 0));
    chk("pending_hit", DW'(bus.pending_hit_o), DW'(model_hit(lk)));
    if (sz != 0) begin
      chk("head_data", bus.wr_data_o, exp_q[0].data);
      chk("head_addr", DW'(bus.wr_addr_o), DW'(exp_q[0].addr));
    end
    if (r) exp_q.delete();
    else if (v && sz < 2) exp_q.push_back('{data: d, addr: a, wben: w});
  endtask

  // Monitor: every accepted write-port transfer retires the oldest expected entry.
  always @(negedge clk) begin
    ent_t e;
    if (rst === 1'b0) begin
      if (bus.wr_valid_o === 1'b1 && bus.wr_ready_i === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL pop_unexpected: got data %h with no expected entry", bus.wr_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("wr_data", bus.wr_data_o, e.data);
          chk("wr_addr", DW'(bus.wr_addr_o), DW'(e.addr));
          chk("wr_en", DW'(bus.wr_en_o), DW'(e.wben && e.addr != '0));
        end
      end else begin
        chk("wr_en_idle", DW'(bus.wr_en_o), '0);
      end
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.in_valid_i = 1'b0;
    bus.result_i = '0;
    bus.rd_addr_i = '0;
    bus.wb_en_i = 1'b0;
    bus.wr_ready_i = 1'b0;
    bus.lookup_addr_i = '0;
    repeat (2) @(posedge clk);

    // Reset state, including cleared storage
    cycle(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    chk("rst_wr_data", bus.wr_data_o, '0);
    chk("rst_wr_addr", DW'(bus.wr_addr_o), '0);

    // Single write with one-cycle latency
    cycle(1'b1, 32'h0000_00F0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b1, 5'd3, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b1, 5'd3, 1'b0);

    // Fill, drop a third push, then drain in order
    cycle(1'b1, 32'hA, 5'd1, 1'b1, 1'b0, 5'd1, 1'b0);
    cycle(1'b1, 32'hB, 5'd2, 1'b1, 1'b0, 5'd2, 1'b0);
    cycle(1'b1, 32'hC, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0);
    cycle(1'b1, 32'hC, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b1, 5'd1, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b1, 5'd1, 1'b0);

    // Full with pop and push together: pop only
    cycle(1'b1, 32'h1, 5'd6, 1'b1, 1'b0, 5'd6, 1'b0);
    cycle(1'b1, 32'h2, 5'd6, 1'b1, 1'b0, 5'd6, 1'b0);
    cycle(1'b1, 32'h3, 5'd6, 1'b1, 1'b1, 5'd6, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b0, 5'd6, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b1, 5'd6, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b1, 5'd6, 1'b0);

    // x0 target and wb_en=0 entries pop silently and never hit
    cycle(1'b1, 32'h11, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    cycle(1'b1, 32'h22, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b0, 5'd4, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b1, 5'd0, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b1, 5'd4, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b0, 5'd4, 1'b0);

    // Hazard hit on a buffered rd 7, cleared after its pop; in-flight input never hits
    cycle(1'b1, 32'h77, 5'd7, 1'b1, 1'b0, 5'd7, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b0, 5'd7, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b1, 5'd7, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b0, 5'd7, 1'b0);

    // Reset with two entries buffered and a push/pop requested in the reset cycle
    cycle(1'b1, 32'h5, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0);
    cycle(1'b1, 32'h6, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0);
    cycle(1'b1, 32'h99, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1);
    cycle(1'b0, 0, 0, 1'b0, 1'b1, 5'd9, 1'b0);
    chk("rst_mid_wr_data", bus.wr_data_o, '0);
    chk("rst_mid_wr_addr", DW'(bus.wr_addr_o), '0);

    // Random traffic, small address range to provoke hazard hits
    for (int n = 0; n < 600; n++) begin
      cycle(1'($urandom_range(0, 1)), DW'($urandom()), AW'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6), AW'($urandom_range(0, 7)),
            ($urandom_range(0, 59) == 0));
    end

    repeat (4) cycle(1'b0, 0, 0, 1'b0, 1'b1, 5'd0, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b0, 5'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
